// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, 4-word lines, burst refill through cache_to_axi.
// Optional hit/miss statistics counters are built when ICACHE_STAT_EN is defined.
module icache_dm #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_data_ok,
  input  logic        inv,
  output logic        mem_en,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_read_data,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic        mem_burst_ok,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  // state    | meaning
  // IDLE     | waiting for a fetch; applies pending invalidate
  // LOOKUP   | tag/data read back, hit returns word
  // MISS_REQ | refill address presented until accepted
  // REFILL   | collecting burst beats into line buffer
  // RESP     | returning the requested word from the refilled line
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP} state_t;

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 28 - INDEX_W;

  state_t state_q, state_d;

  logic [29:0]          req_q;
  logic [1:0]           offset;
  logic [INDEX_W-1:0]   index;
  logic [TAG_W-1:0]     req_tag;
  logic [INDEX_W-1:0]   cpu_idx;

  logic [LINES-1:0]     valid_q;
  logic                 inv_pend;
  logic [1:0]           beat_q;

  logic [TAG_W-1:0]     tag_ram  [LINES];
  logic [3:0][31:0]     data_ram [LINES];
  logic [TAG_W-1:0]     tag_q;
  logic [3:0][31:0]     line_q;
  logic [3:0][31:0]     line_buf;
  logic [3:0][31:0]     refill_line;

  logic        hit;
  logic        accept;
  logic        beat_take;
  logic        refill_done;
  logic        data_ok_c;
  logic        mem_en_c;
  logic [31:0] rdata_c;
  logic        unused_addr_bits;

  assign offset  = req_q[1:0];
  assign index   = req_q[INDEX_W+1:2];
  assign req_tag = req_q[29:INDEX_W+2];
  assign cpu_idx = cpu_addr[4 +: INDEX_W];
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign hit         = valid_q[index] && (tag_q == req_tag);
  assign accept      = (state_q == IDLE) && cpu_req && !rst;
  assign beat_take   = (state_q == REFILL) && mem_data_ok && !rst;
  assign refill_done = beat_take && mem_burst_ok;

  always_comb begin
    refill_line         = line_buf;
    refill_line[beat_q] = mem_read_data;
  end

  always_comb begin
    state_d   = state_q;
    data_ok_c = 1'b0;
    mem_en_c  = 1'b0;
    rdata_c   = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          data_ok_c = 1'b1;
          rdata_c   = line_q[offset];
          state_d   = IDLE;
        end else begin
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_en_c = 1'b1;
        if (mem_addr_ok) state_d = REFILL;
      end
      REFILL: begin
        if (mem_data_ok && mem_burst_ok) state_d = RESP;
      end
      RESP: begin
        data_ok_c = 1'b1;
        rdata_c   = line_buf[offset];
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet for the whole reset cycle, not just after it.
  assign cpu_data_ok = data_ok_c && !rst;
  assign cpu_rdata   = rst ? 32'd0 : rdata_c;
  assign mem_en      = mem_en_c && !rst;
  assign mem_wen     = 1'b0;
  assign mem_addr    = rst ? 32'd0 : {req_q[29:2], 4'b0000};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      inv_pend <= 1'b0;
      beat_q   <= 2'd0;
      req_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) req_q <= cpu_addr[31:2];
      // Invalidate is deferred while a request is in flight so the refill still lands.
      if (state_q == IDLE) begin
        if (inv || inv_pend) valid_q <= '0;
        inv_pend <= 1'b0;
      end else if (inv) begin
        inv_pend <= 1'b1;
      end
      if (beat_take) beat_q <= mem_burst_ok ? 2'd0 : beat_q + 2'd1;
      if (refill_done) valid_q[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q  <= tag_ram[cpu_idx];
      line_q <= data_ram[cpu_idx];
    end
    if (beat_take) line_buf[beat_q] <= mem_read_data;
    if (refill_done) begin
      tag_ram[index]  <= req_tag;
      data_ram[index] <= refill_line;
    end
  end

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) hit_q  <= hit_q + 32'd1;
      else     miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: scoreboard queue of expected words, negedge monitor.
module tb_icache_dm;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_data_ok;
  logic        inv;
  logic        mem_en;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_read_data;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic        mem_burst_ok;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_hit  = 0;
  int exp_miss = 0;
  logic [31:0] sb_q[$];
  logic prev_ok = 1'b0;

  icache_dm #(.INDEX_W(6)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_rdata(cpu_rdata), .cpu_data_ok(cpu_data_ok), .inv(inv),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_read_data(mem_read_data), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_burst_ok(mem_burst_ok),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: every cpu_data_ok pops one expected word.
  always @(negedge clk) begin
    if (cpu_data_ok) begin
      if (prev_ok) chk("data_ok_back_to_back", {31'd0, cpu_data_ok}, 32'd0);
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_data_ok: rdata %h with no expected entry", cpu_rdata);
      end else begin
        chk("cpu_rdata", cpu_rdata, sb_q.pop_front());
      end
    end
    prev_ok = cpu_data_ok;
  end

  task automatic check_stats();
`ifdef ICACHE_STAT_EN
    chk("hit_cnt", hit_cnt, exp_hit);
    chk("miss_cnt", miss_cnt, exp_miss);
`else
    chk("hit_cnt", hit_cnt, 32'd0);
    chk("miss_cnt", miss_cnt, 32'd0);
`endif
  endtask

  task automatic do_req(input logic [31:0] addr, input bit miss,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3,
                        input int nbeats, input logic [31:0] exp,
                        input int addr_wait, input bit inv_mid, input bit inv_at_req);
    logic [31:0] w [4];
    logic [31:0] addr_seen;
    bit found;
    int lat;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    sb_q.push_back(exp);
    @(posedge clk); #2;
    cpu_addr = addr;
    cpu_req  = 1'b1;
    inv      = inv_at_req;
    if (!miss) begin
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (cpu_data_ok) begin lat = i; break; end
      end
      chk("hit_latency", lat, 2);
    end else begin
      if (inv_at_req) begin @(posedge clk); #2; inv = 1'b0; end
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (mem_en) begin found = 1'b1; break; end
      end
      if (!found) begin
        timeout("mem_en_wait");
        @(posedge clk); #2; cpu_req = 1'b0;
        return;
      end
      chk("mem_addr", mem_addr, {addr[31:4], 4'h0});
      chk("mem_wen", {31'd0, mem_wen}, 32'd0);
      addr_seen = mem_addr;
      for (int k = 0; k < addr_wait; k++) begin
        @(posedge clk); #2;
        @(negedge clk);
        chk("mem_en_held", {31'd0, mem_en}, 32'd1);
        chk("mem_addr_stable", mem_addr, addr_seen);
        chk("no_data_ok_while_waiting", {31'd0, cpu_data_ok}, 32'd0);
      end
      @(posedge clk); #2; mem_addr_ok = 1'b1;
      @(posedge clk); #2; mem_addr_ok = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
        mem_data_ok   = 1'b1;
        mem_read_data = w[b];
        mem_burst_ok  = (b == nbeats - 1);
        inv           = inv_mid && (b == 1);
        @(posedge clk); #2;
      end
      mem_data_ok = 1'b0; mem_burst_ok = 1'b0; inv = 1'b0; mem_read_data = '0;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (cpu_data_ok) begin found = 1'b1; break; end
      end
      if (!found) timeout("refill_data_ok_wait");
    end
    @(posedge clk); #2;
    cpu_req = 1'b0;
    if (miss) exp_miss++; else exp_hit++;
    check_stats();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; inv = 1'b0;
    mem_read_data = '0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_burst_ok = 1'b0;
    @(negedge clk);
    chk("rst_data_ok", {31'd0, cpu_data_ok}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_stats();

    // First fill, then hits out of the same line.
    do_req(32'h40,  1, 32'h11, 32'h22, 32'h33, 32'h44, 4, 32'h11, 0, 0, 0);
    do_req(32'h4C,  0, 0, 0, 0, 0, 0, 32'h44, 0, 0, 0);
    do_req(32'h48,  0, 0, 0, 0, 0, 0, 32'h33, 0, 0, 0);
    // Conflict on index 4, then the evicted line misses again with an early burst end.
    do_req(32'h440, 1, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4, 32'hA0, 0, 0, 0);
    do_req(32'h444, 0, 0, 0, 0, 0, 0, 32'hA1, 0, 0, 0);
    do_req(32'h40,  1, 32'h55, 32'h66, 0, 0, 2, 32'h55, 0, 0, 0);
    do_req(32'h44,  0, 0, 0, 0, 0, 0, 32'h66, 0, 0, 0);
    // Invalidate during refill: data still returned, line gone afterwards.
    do_req(32'h100, 1, 32'h1, 32'h2, 32'h3, 32'h4, 4, 32'h1, 0, 1, 0);
    do_req(32'h100, 1, 32'h5, 32'h6, 32'h7, 32'h8, 4, 32'h5, 0, 0, 0);
    do_req(32'h104, 0, 0, 0, 0, 0, 0, 32'h6, 0, 0, 0);
    // Invalidate together with a request in IDLE: the request misses.
    do_req(32'h104, 1, 32'h9, 32'hA, 32'hB, 32'hC, 4, 32'hA, 0, 0, 1);

    // Reset on the second refill beat.
    @(posedge clk); #2;
    cpu_addr = 32'h80; cpu_req = 1'b1;
    begin : rst_mid
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (mem_en) begin found = 1'b1; break; end
      end
      if (!found) timeout("rst_test_mem_en_wait");
    end
    @(posedge clk); #2; mem_addr_ok = 1'b1;
    @(posedge clk); #2; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_read_data = 32'hBAD0;
    @(posedge clk); #2; mem_read_data = 32'hBAD1; rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mid_data_ok", {31'd0, cpu_data_ok}, 32'd0);
    chk("rst_mid_rdata", cpu_rdata, 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; mem_burst_ok = 1'b1; mem_read_data = 32'hBAD3;
    @(negedge clk);
    chk("stray_beat_mem_en", {31'd0, mem_en}, 32'd0);
    chk("stray_beat_data_ok", {31'd0, cpu_data_ok}, 32'd0);
    @(posedge clk); #2;
    mem_data_ok = 1'b0; mem_burst_ok = 1'b0; mem_read_data = '0;
    @(negedge clk);
    chk("after_stray_data_ok", {31'd0, cpu_data_ok}, 32'd0);
    exp_hit = 0; exp_miss = 0;
    check_stats();
    do_req(32'h80,  1, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 4, 32'hD0, 0, 0, 0);
    do_req(32'h40,  1, 32'h11, 32'h22, 32'h33, 32'h44, 4, 32'h11, 0, 0, 0);

    // Slow address handshake.
    do_req(32'h20C, 1, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 4, 32'hC3, 5, 0, 0);
    do_req(32'h208, 0, 0, 0, 0, 0, 0, 32'hC2, 0, 0, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
